// File: rtl/ex_div_pkg.sv
// ex_div_pkg
// Shared definitions for the EX-stage divider: FSM state encoding, signedness
// selectors and the active levels of reset and the stall request line.
// No ports; imported by ex_div and ex_div_step.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic DIV_SIGNED      = 1'b1;
  localparam logic DIV_UNSIGNED    = 1'b0;

  localparam logic RST_ENABLE      = 1'b1;
  localparam logic STALLREQ_ENABLE = 1'b1;

endpackage

// File: rtl/ex_div_step.sv
// ex_div_step
// One combinational radix-2 restoring division iteration.
// Ports:
//   rem_i      partial remainder before the step
//   quo_i      dividend/quotient shift register before the step
//   divisor_i  divisor magnitude
//   rem_o      partial remainder after the step
//   quo_o      quotient shift register after the step (new bit in LSB)
module ex_div_step
  import ex_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  // The shifted remainder can need DATA_W+1 bits; doing the trial subtract at
  // that width makes the borrow bit a clean "less than" flag with no overflow.
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[DATA_W-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (!diff[DATA_W]) begin
      rem_o = diff[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o = shifted[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div.sv
// ex_div
// Multi-cycle signed/unsigned restoring divider for the EX stage. Requests an
// EX stall while a divide is in flight and holds the result until EX advances.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start_i             EX holds a divide (kept high while stalled)
//   signed_i            1 = signed divide
//   annul_i             flush of the EX instruction; cancels everything
//   ex_stall_i          EX stall bit; 0 = result consumed at this edge
//   dividend_i          dividend
//   divisor_i           divisor
//   stallreq_o          EX stall request to the stall controller
//   ready_o             quotient_o/remainder_o valid
//   quotient_o          quotient
//   remainder_o         remainder
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic              annul_i,
  input  logic              ex_stall_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              stallreq_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  div_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] rem_reg, rem_next;
  logic [DATA_W-1:0] quo_reg, quo_next;
  logic [DATA_W-1:0] dvs_reg, dvs_next;
  logic              q_neg_reg, q_neg_next;
  logic              r_neg_reg, r_neg_next;
  logic [DATA_W-1:0] quotient_reg, quotient_next;
  logic [DATA_W-1:0] remainder_reg, remainder_next;

  logic [DATA_W-1:0] step_rem, step_quo;

  ex_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_reg),
    .quo_i     (quo_reg),
    .divisor_i (dvs_reg),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_reg     <= DIV_IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rem_reg       <= rem_next;
      quo_reg       <= quo_next;
      dvs_reg       <= dvs_next;
      q_neg_reg     <= q_neg_next;
      r_neg_reg     <= r_neg_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rem_next       = rem_reg;
    quo_next       = quo_reg;
    dvs_next       = dvs_reg;
    q_neg_next     = q_neg_reg;
    r_neg_next     = r_neg_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;

    if (annul_i) begin
      state_next = DIV_IDLE;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (start_i) begin
            if (divisor_i == '0) begin
              // Divide-by-zero skips the iterations entirely.
              state_next     = DIV_DONE;
              quotient_next  = '1;
              remainder_next = dividend_i;
            end else begin
              state_next = DIV_BUSY;
              // Magnitudes only; the most-negative value maps to its own
              // bit pattern, which is the correct unsigned magnitude.
              quo_next   = (signed_i == DIV_SIGNED && dividend_i[DATA_W-1])
                           ? -dividend_i : dividend_i;
              dvs_next   = (signed_i == DIV_SIGNED && divisor_i[DATA_W-1])
                           ? -divisor_i : divisor_i;
              rem_next   = '0;
              cnt_next   = '0;
              q_neg_next = signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
              r_neg_next = signed_i & dividend_i[DATA_W-1];
            end
          end
        end
        DIV_BUSY: begin
          rem_next = step_rem;
          quo_next = step_quo;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(DATA_W - 1)) begin
            state_next     = DIV_DONE;
            quotient_next  = q_neg_reg ? -step_quo : step_quo;
            remainder_next = r_neg_reg ? -step_rem : step_rem;
          end
        end
        DIV_DONE: begin
          if (!ex_stall_i) state_next = DIV_IDLE;
        end
        default: state_next = DIV_IDLE;
      endcase
    end
  end

  // Deliberately zero in DONE so the stall controller's response on
  // ex_stall_i can never feed back into this request combinationally.
  assign stallreq_o  = (start_i && !annul_i && state_reg != DIV_DONE)
                       ? STALLREQ_ENABLE : ~STALLREQ_ENABLE;
  assign ready_o     = (state_reg == DIV_DONE) && !annul_i;
  assign quotient_o  = quotient_reg;
  assign remainder_o = remainder_reg;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div
// Directed bench for ex_div. Stimulus pushes the hand-computed {q, r} into a
// scoreboard queue; a monitor pops and compares whenever a result is consumed.
module tb_ex_div;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic         signed_i = 1'b0;
  logic         annul_i = 1'b0;
  logic         ex_stall_i;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic         stallreq_o;
  logic         ready_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;

  // The stall controller is modelled either as echoing the request or forced.
  logic stall_follow = 1'b1;
  logic stall_force  = 1'b0;
  assign ex_stall_i = stall_follow ? stallreq_o : stall_force;

  ex_div #(.DATA_W(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .annul_i     (annul_i),
    .ex_stall_i  (ex_stall_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .stallreq_o  (stallreq_o),
    .ready_o     (ready_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] mon_exp;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed on a DONE cycle where EX is not stalled.
  always @(negedge clk) begin
    if (!rst && ready_o && !ex_stall_i) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got q=0x%08h r=0x%08h, want no result",
                 quotient_o, remainder_o);
      end else begin
        mon_exp = sb.pop_front();
        check("quotient", quotient_o, mon_exp[2*W-1:W]);
        check("remainder", remainder_o, mon_exp[W-1:0]);
        $display("txn t=%0t q=0x%08h r=0x%08h exp_q=0x%08h exp_r=0x%08h",
                 $time, quotient_o, remainder_o, mon_exp[2*W-1:W], mon_exp[W-1:0]);
      end
    end
  end

  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn,
                       input logic [W-1:0] q, input logic [W-1:0] r);
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = dvd;
    divisor_i  = dvs;
    sb.push_back({q, r});
  endtask

  // Called in cycle 0 (just after the edge). Counts cycles until ready_o and
  // the cycles with stallreq_o high; scrambles operands after capture.
  task automatic wait_ready(output int cyc, output int nstall);
    cyc = 0;
    nstall = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (stallreq_o) nstall++;
      if (ready_o) return;
      @(posedge clk);
      #1;
      dividend_i = $urandom;
      divisor_i  = $urandom;
      cyc++;
    end
    cyc = -1;
  endtask

  task automatic run_div(input string name, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic sgn, input logic [W-1:0] q, input logic [W-1:0] r,
                         input int exp_lat);
    int cyc, nstall;
    @(posedge clk);
    #1;
    issue(dvd, dvs, sgn, q, r);
    wait_ready(cyc, nstall);
    if (cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no ready_o, want ready_o in cycle %0d", name, exp_lat);
      void'(sb.pop_back());
      start_i = 1'b0;
      return;
    end
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_stall_cycles"}, nstall, exp_lat);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    #1;
    check({name, "_idle_after"}, {31'd0, ready_o}, '0);
  endtask

  initial begin : main
    int cyc, nstall, bad;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_ready", {31'd0, ready_o}, '0);
    check("reset_stallreq", {31'd0, stallreq_o}, '0);
    check("reset_quotient", quotient_o, '0);
    check("reset_remainder", remainder_o, '0);

    run_div("u100_7",     32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33);
    run_div("s-7_2",      32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   33);
    run_div("s7_-2",      32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          33);
    run_div("uFFF9_2",    32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          33);
    run_div("u5_0",       32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          1);
    run_div("s-5_0",      32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB,   1);
    run_div("s_ovf",      32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          33);

    // Annul in cycle 10 of the operation.
    @(posedge clk);
    #1;
    issue(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
    end
    annul_i = 1'b1;
    void'(sb.pop_back());
    #1;
    check("annul_stallreq", {31'd0, stallreq_o}, '0);
    check("annul_ready", {31'd0, ready_o}, '0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (ready_o || stallreq_o) bad++;
      @(posedge clk);
      #1;
    end
    check("annul_no_ready", bad, 0);
    run_div("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);

    // Held in DONE by ex_stall_i for 3 cycles, then back-to-back restart.
    stall_follow = 1'b0;
    stall_force  = 1'b1;
    @(posedge clk);
    #1;
    issue(32'd50, 32'd8, 1'b0, 32'd6, 32'd2);
    wait_ready(cyc, nstall);
    check("hold_latency", cyc, 33);
    dividend_i = 32'd77;
    divisor_i  = 32'd5;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_ready", {31'd0, ready_o}, 32'd1);
      check("hold_stallreq", {31'd0, stallreq_o}, '0);
      check("hold_quotient", quotient_o, 32'd6);
      check("hold_remainder", remainder_o, 32'd2);
      @(posedge clk);
      #1;
    end
    stall_force = 1'b0;
    #1;
    check("release_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk);
    #1;
    stall_follow = 1'b1;
    issue(32'd20, 32'd6, 1'b0, 32'd3, 32'd2);
    #1;
    check("b2b_stallreq", {31'd0, stallreq_o}, 32'd1);
    check("b2b_ready", {31'd0, ready_o}, '0);
    wait_ready(cyc, nstall);
    check("b2b_latency", cyc, 33);
    @(posedge clk);
    #1;
    start_i = 1'b0;

    // Reset in cycle 15 of an operation.
    @(posedge clk);
    #1;
    issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    check("rst_ready", {31'd0, ready_o}, '0);
    check("rst_stallreq", {31'd0, stallreq_o}, '0);
    check("rst_quotient", quotient_o, '0);
    check("rst_remainder", remainder_o, '0);
    run_div("u1_1", 32'd1, 32'd1, 1'b0, 32'd1, 32'd0, 33);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage.
- It is the requester side of the stall protocol: it raises the EX-stage stall request while a division is in flight.
- It then holds its result until the stall bus shows that EX is advancing.
- Signed and unsigned; quotient and remainder are delivered together.

Parameters:
- DATA_W, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset; synchronous, active-high (`RST_ENABLE).
- start_i  in  1  EX holds a divide instruction; held high by EX while stalled.
- signed_i  in  1  1 = signed divide, 0 = unsigned.
- annul_i  in  1  flush of the EX instruction (jump/interrupt); cancels any operation.
- ex_stall_i  in  1  EX bit of the stall bus; 0 = EX/MEM register loads at this edge.
- dividend_i  in  DATA_W  dividend.
- divisor_i  in  DATA_W  divisor.
- stallreq_o  out  1  to the stall controller's EX stall request input.
- ready_o  out  1  quotient_o and remainder_o are valid.
- quotient_o  out  DATA_W  quotient.
- remainder_o  out  DATA_W  remainder.

Behaviour:
- States: IDLE, BUSY, DONE. The state register is clocked; reset (sync, high) forces IDLE, counter = 0, and all outputs 0.
- IDLE:
  - If start_i=1 and annul_i=0 and divisor_i≠0: capture |dividend| and |divisor| (absolute value only when signed_i=1). Latch the quotient sign (signed_i & signs differ) and the remainder sign (signed_i & dividend negative). Clear the partial remainder and counter. Go to BUSY.
  - If start_i=1 and annul_i=0 and divisor_i=0: go directly to DONE with quotient = all-ones and remainder = dividend_i unchanged.
  - Otherwise stay in IDLE.
- BUSY:
  - Per cycle: shift {rem,quo} left 1; if the shifted rem ≥ divisor, subtract and set the quo LSB.
  - The subtract uses a DATA_W+1-bit compare so there is no overflow.
  - Counter increments; after DATA_W iterations go to DONE.
  - On DONE entry, apply the latched signs (two's-complement negate) and register the results.
- DONE:
  - ready_o=1; results held stable.
  - If ex_stall_i=0, the result is consumed at this edge: go to IDLE.
  - Otherwise stay in DONE, with no new start regardless of start_i.
- stallreq_o (combinational) = start_i & ~annul_i & (state≠DONE).
  - It asserts in the same cycle start_i first appears, so the pipeline freezes immediately.
  - It is 0 in DONE, so no combinational loop exists through ex_stall_i.
  - ex_stall_i is only examined in DONE.
- ready_o = (state==DONE) & ~annul_i.
- Latency, with start sampled at edge 0:
  - Normal divide: BUSY in cycles 1..DATA_W, DONE from cycle DATA_W+1; stallreq_o is high for DATA_W+1 cycles (0..DATA_W).
  - Divide-by-zero: ready_o in cycle 1; stallreq_o high for cycle 0 only.
- annul_i=1 in any state: go to IDLE next edge, results discarded. stallreq_o and ready_o are 0 in that cycle.
- Signed overflow (most-negative ÷ −1) falls out naturally: quotient = most-negative, remainder = 0. No trap.
- Back-to-back divides: after leaving DONE through IDLE, a new start_i in the first IDLE cycle begins the next operation. The minimum gap is one IDLE cycle, during which stallreq_o is already high.
- Reset mid-operation: IDLE next edge, with no residual ready_o.
- The divider never reads operands after the IDLE capture; changes in the operand inputs during BUSY/DONE are ignored.

Decomposition:
- Add to DEFINE.v:
  - `DIV_IDLE, `DIV_BUSY, `DIV_DONE state encodings.
  - `DIV_DATA_BUS [DATA_W-1:0].
  - `DIV_SIGNED / `DIV_UNSIGNED.
  - Reuse the existing `RST_ENABLE and `STALLREQ_ENABLE.
- One natural sub-module, div_step: combinational single restoring iteration, inputs {rem,quo,divisor}, outputs {rem',quo'}.
- FSM, counter and sign fix-up stay in ex_div.

Test Plan:
- Unsigned 100 ÷ 7, start held, ex_stall_i follows stallreq:
  - stallreq_o high for cycles 0..32 (33 cycles).
  - ready_o in cycle 33 with q=14, r=2.
  - With ex_stall_i=0, IDLE in cycle 34.
- Signed −7 ÷ 2 → q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 ÷ −2 → q=0xFFFFFFFD, r=1. Unsigned 0xFFFFFFF9 ÷ 2 → q=0x7FFFFFFC, r=1.
- Divide-by-zero 5 ÷ 0 → ready_o in cycle 1, q=0xFFFFFFFF, r=5, stallreq_o high only in cycle 0. Signed 0x80000000 ÷ 0xFFFFFFFF → q=0x80000000, r=0.
- annul_i pulsed in cycle 10 of BUSY:
  - stallreq_o=0 that cycle, IDLE next.
  - start_i dropped from cycle 11; no ready_o ever.
  - A fresh 9 ÷ 3 then gives q=3, r=0.
- ex_stall_i held 1 for 3 cycles in DONE:
  - ready_o and the results stay stable, stallreq_o=0, no restart despite start_i=1.
  - ex_stall_i=0 → IDLE; start_i still high with new operands 20 ÷ 6 → stallreq_o high immediately, result q=3, r=2.
- rst asserted in cycle 15 of BUSY → all outputs 0 next cycle, state IDLE; a subsequent 1 ÷ 1 → q=1, r=0.
